multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle FSM that sequences the RV32I/RV64I Dataflow: fetch over a request/acknowledge memory port, decode, execute, memory access and writeback.
- Drives every Dataflow control input and the memory read/write strobes.
- Consumes opcode/funct3/funct7, ALU flags and trap from the Dataflow.
- Sits between Dataflow and the memory interconnect inside the core top.

Parameters:
RV64I, 0, 1 enables OP-32/OP-IMM-32 decode and the aluy_src output (tied 0 when 0).

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
opcode  in  7  ir[6:0]
funct3  in  3  ir[14:12]
funct7  in  7  ir[31:25]
zero, negative, carry_out, overflow  in  1 each  ALU flags
trap  in  1  Dataflow trap taken this cycle
mem_ack  in  1  memory access complete
mem_rd_en, mem_wr_en  out  1 each  memory strobes, held until mem_ack
alua_src, alub_src, aluy_src, sub, arithmetic, alupc_src, pc_src, pc_en, wr_reg_en, ir_en, mem_addr_src, ecall, illegal_instruction  out  1 each  Dataflow controls
alu_src  out  3  ALU op select
wr_reg_src  out  2  00 aluY, 01 CSR (unused, never driven), 10 rd_data, 11 pc+4

Behaviour:
- Reset: state = FETCH, all outputs 0 (outputs are combinational from state and inputs; 0 while reset is asserted).
- Default for every output in every state: 0.
- States: FETCH, DECODE, EXECUTE, MEMORY, HALT.

FETCH:
- mem_rd_en=1, mem_addr_src=0.
- On mem_ack: ir_en=1, go to DECODE. mem_ack on a fetch cycle therefore gives one IR load.

DECODE (1 cycle):
- Legal opcode: go to EXECUTE (all except LOAD/STORE) or MEMORY (LOAD/STORE).
- Unknown opcode, or funct7 not in {0000000, 0100000} where required: illegal_instruction=1 for exactly 1 cycle, go to FETCH.
- SYSTEM with funct3=000 and ir imm=0 is reported as ecall=1 for 1 cycle, go to FETCH. The imm is not visible here, so any SYSTEM funct3=000 is treated as ecall.
- FENCE: pc_en=1, go to FETCH (NOP).

EXECUTE (1 cycle, then FETCH; pc_en=1 and wr_reg_en=1 unless noted):
- OP:
  - alu_src=funct3.
  - sub = funct7[5] when funct3=000; sub=1 when funct3 is 010 or 011.
  - arithmetic = funct7[5] when funct3=101.
- OP-IMM:
  - As OP with alub_src=1.
  - sub=0 except SLTI/SLTIU (sub=1).
  - arithmetic = funct7[5] only when funct3=101.
- LUI: alub_src=1, alu_src=000 (rs1 is forced to x0 by the Dataflow).
- AUIPC: alua_src=1, alub_src=1, alu_src=000.
- JAL: wr_reg_src=11, pc_src=1, alupc_src=0.
- JALR: wr_reg_src=11, pc_src=1, alupc_src=1.
- BRANCH:
  - sub=1, alu_src=000, wr_reg_en=0.
  - Taken condition by funct3: beq zero; bne !zero; blt n^v; bge !(n^v); bltu !carry_out; bgeu carry_out.
  - pc_src = taken.
  - funct3 010/011 is caught as illegal in DECODE.
- RV64I=1, OP-32/OP-IMM-32: as OP/OP-IMM with aluy_src=1.

MEMORY:
- mem_addr_src=1, alub_src=1, alu_src=000.
- LOAD holds mem_rd_en; STORE holds mem_wr_en.
- On mem_ack: pc_en=1. LOAD also asserts wr_reg_en=1, wr_reg_src=10. Go to FETCH.
- Without mem_ack the state holds indefinitely with no timeout.

Trap:
- trap=1 in any state forces pc_en=0, wr_reg_en=0, ir_en=0 and mem strobes 0, and next state = FETCH. The Dataflow loads the trap address itself.
- trap has priority over mem_ack in the same cycle.

HALT:
- Unreachable except by opcode 0000000 (all-zero IR), entered from DECODE. That opcode does not raise illegal_instruction.
- All outputs 0; exit only via reset or trap.

Reset:
- Reset mid-access drops strobes the same cycle and restarts at FETCH.

Test Plan:
- Reset, then ack fetch with ADD x3,x1,x2 (0x002081B3) -> ir_en 1 cycle, then EXECUTE with alu_src=000, sub=0, wr_reg_en=1, pc_en=1; back to FETCH 3 cycles after ack.
- SUB (funct7=0100000) -> sub=1. SRAI (funct7=0100000, funct3=101) -> arithmetic=1, alub_src=1.
- BLT with negative=1, overflow=0 -> pc_src=1. Same with overflow=1 -> pc_src=0. BGEU with carry_out=1 -> pc_src=1. wr_reg_en=0 in all cases.
- LW with mem_ack delayed 5 cycles -> mem_rd_en and mem_addr_src high 5 cycles; on ack wr_reg_src=10, wr_reg_en=1, pc_en=1 for 1 cycle. SW -> mem_wr_en held, wr_reg_en=0.
- Opcode 0x7F -> illegal_instruction exactly 1 cycle, then FETCH with pc_en=0.
- trap asserted during MEMORY together with mem_ack -> pc_en=0, wr_reg_en=0, next state FETCH. Reset asserted mid-fetch -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Memory request/acknowledge port between the control unit and the
// memory interconnect.
interface multicycle_control_unit_if;
  logic mem_rd_en;
  logic mem_wr_en;
  logic mem_ack;

  modport master (
    output mem_rd_en,
    output mem_wr_en,
    input  mem_ack
  );

  modport slave (
    input  mem_rd_en,
    input  mem_wr_en,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer for the RV32I/RV64I dataflow:
// fetch, decode, execute, memory access and writeback.
module multicycle_control_unit #(
  parameter bit RV64I = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       negative,
  input  logic       carry_out,
  input  logic       overflow,
  input  logic       trap,
  multicycle_control_unit_if.master mem,
  output logic       alua_src,
  output logic       alub_src,
  output logic       aluy_src,
  output logic       sub,
  output logic       arithmetic,
  output logic       alupc_src,
  output logic       pc_src,
  output logic       pc_en,
  output logic       wr_reg_en,
  output logic       ir_en,
  output logic       mem_addr_src,
  output logic       ecall,
  output logic       illegal_instruction,
  output logic [2:0] alu_src,
  output logic [1:0] wr_reg_src
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_HALT   = 7'b0000000;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEMORY, HALT
  } state_t;

  state_t state, next;

  logic rd_en, wr_en;
  logic legal, taken, f7_ok, sh_ok, is_shift, is_mem;

  assign mem.mem_rd_en = rd_en;
  assign mem.mem_wr_en = wr_en;

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  // RV64 shifts carry shamt[5] in funct7[0]
  always_comb begin
    f7_ok    = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    sh_ok    = RV64I ? ((funct7[6:1] == 6'b000000) ||
                        (funct7[6:1] == 6'b010000)) : f7_ok;
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    is_mem   = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    legal    = 1'b0;
    case (opcode)
      OPC_OP:      legal = f7_ok;
      OPC_OPIMM:   legal = is_shift ? sh_ok : 1'b1;
      OPC_OP32:    legal = RV64I && f7_ok;
      OPC_OPIMM32: legal = RV64I && (is_shift ? f7_ok : 1'b1);
      OPC_BRANCH:  legal = funct3[2:1] != 2'b01;
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_STORE, OPC_FENCE:
        legal = 1'b1;
      default:     legal = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = negative ^ overflow;
      3'b101:  taken = !(negative ^ overflow);
      3'b110:  taken = !carry_out;
      3'b111:  taken = carry_out;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next                = state;
    rd_en               = 1'b0;
    wr_en               = 1'b0;
    alua_src            = 1'b0;
    alub_src            = 1'b0;
    aluy_src            = 1'b0;
    sub                 = 1'b0;
    arithmetic          = 1'b0;
    alupc_src           = 1'b0;
    pc_src              = 1'b0;
    pc_en               = 1'b0;
    wr_reg_en           = 1'b0;
    ir_en               = 1'b0;
    mem_addr_src        = 1'b0;
    ecall               = 1'b0;
    illegal_instruction = 1'b0;
    alu_src             = 3'b000;
    wr_reg_src          = 2'b00;
    if (!reset) begin
      unique case (state)
        FETCH: begin
          rd_en = 1'b1;
          if (mem.mem_ack) begin
            ir_en = 1'b1;
            next  = DECODE;
          end
        end
        DECODE: begin
          next = FETCH;
          if (opcode == OPC_HALT)
            next = HALT;
          else if (opcode == OPC_SYSTEM && funct3 == 3'b000)
            ecall = 1'b1;
          else if (opcode == OPC_FENCE)
            pc_en = 1'b1;
          else if (!legal)
            illegal_instruction = 1'b1;
          else if (is_mem)
            next = MEMORY;
          else
            next = EXECUTE;
        end
        EXECUTE: begin
          next      = FETCH;
          pc_en     = 1'b1;
          wr_reg_en = 1'b1;
          case (opcode)
            OPC_OP, OPC_OP32: begin
              alu_src    = funct3;
              sub        = (funct3 == 3'b000) ? funct7[5] :
                           (funct3[2:1] == 2'b01);
              arithmetic = (funct3 == 3'b101) && funct7[5];
              aluy_src   = RV64I && (opcode == OPC_OP32);
            end
            OPC_OPIMM, OPC_OPIMM32: begin
              alub_src   = 1'b1;
              alu_src    = funct3;
              sub        = funct3[2:1] == 2'b01;
              arithmetic = (funct3 == 3'b101) && funct7[5];
              aluy_src   = RV64I && (opcode == OPC_OPIMM32);
            end
            OPC_LUI:   alub_src = 1'b1;
            OPC_AUIPC: begin
              alua_src = 1'b1;
              alub_src = 1'b1;
            end
            OPC_JAL: begin
              wr_reg_src = 2'b11;
              pc_src     = 1'b1;
            end
            OPC_JALR: begin
              wr_reg_src = 2'b11;
              pc_src     = 1'b1;
              alupc_src  = 1'b1;
            end
            OPC_BRANCH: begin
              sub       = 1'b1;
              wr_reg_en = 1'b0;
              pc_src    = taken;
            end
            default: ;
          endcase
        end
        MEMORY: begin
          mem_addr_src = 1'b1;
          alub_src     = 1'b1;
          rd_en        = opcode == OPC_LOAD;
          wr_en        = opcode != OPC_LOAD;
          if (mem.mem_ack && !trap) begin
            pc_en = 1'b1;
            next  = FETCH;
            if (opcode == OPC_LOAD) begin
              wr_reg_en  = 1'b1;
              wr_reg_src = 2'b10;
            end
          end
        end
        HALT: ;
        default: next = FETCH;
      endcase
      // the dataflow redirects to the trap vector on its own
      if (trap) begin
        pc_en     = 1'b0;
        wr_reg_en = 1'b0;
        ir_en     = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        next      = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction
// sequences with hand-computed control words per cycle.
module tb_multicycle_control_unit;

  logic clock = 1'b0;
  logic reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic zero, negative, carry_out, overflow, trap;
  logic alua_src, alub_src, aluy_src, sub, arithmetic;
  logic alupc_src, pc_src, pc_en, wr_reg_en, ir_en;
  logic mem_addr_src, ecall, illegal_instruction;
  logic [2:0] alu_src;
  logic [1:0] wr_reg_src;
  logic [19:0] ctl;

  int total = 0;
  int bad = 0;

  multicycle_control_unit_if mif ();

  multicycle_control_unit dut (
    .clock               (clock),
    .reset               (reset),
    .opcode              (opcode),
    .funct3              (funct3),
    .funct7              (funct7),
    .zero                (zero),
    .negative            (negative),
    .carry_out           (carry_out),
    .overflow            (overflow),
    .trap                (trap),
    .mem                 (mif),
    .alua_src            (alua_src),
    .alub_src            (alub_src),
    .aluy_src            (aluy_src),
    .sub                 (sub),
    .arithmetic          (arithmetic),
    .alupc_src           (alupc_src),
    .pc_src              (pc_src),
    .pc_en               (pc_en),
    .wr_reg_en           (wr_reg_en),
    .ir_en               (ir_en),
    .mem_addr_src        (mem_addr_src),
    .ecall               (ecall),
    .illegal_instruction (illegal_instruction),
    .alu_src             (alu_src),
    .wr_reg_src          (wr_reg_src)
  );

  always #5 clock = ~clock;

  assign ctl = {alua_src, alub_src, aluy_src, sub, arithmetic,
                alupc_src, pc_src, pc_en, wr_reg_en, ir_en,
                mem_addr_src, ecall, illegal_instruction,
                mif.mem_rd_en, mif.mem_wr_en, alu_src, wr_reg_src};

  localparam logic [19:0] ALUA = 20'h80000;
  localparam logic [19:0] ALUB = 20'h40000;
  localparam logic [19:0] SUB  = 20'h10000;
  localparam logic [19:0] ARI  = 20'h08000;
  localparam logic [19:0] APC  = 20'h04000;
  localparam logic [19:0] PSRC = 20'h02000;
  localparam logic [19:0] PCE  = 20'h01000;
  localparam logic [19:0] WRE  = 20'h00800;
  localparam logic [19:0] IRE  = 20'h00400;
  localparam logic [19:0] MAS  = 20'h00200;
  localparam logic [19:0] ECL  = 20'h00100;
  localparam logic [19:0] ILL  = 20'h00080;
  localparam logic [19:0] RD   = 20'h00040;
  localparam logic [19:0] WR   = 20'h00020;
  localparam logic [19:0] F010 = 20'h00008;
  localparam logic [19:0] F101 = 20'h00014;
  localparam logic [19:0] S10  = 20'h00002;
  localparam logic [19:0] S11  = 20'h00003;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic ack, input logic tr,
                     input string tag, input logic [19:0] exp);
    mif.mem_ack = ack;
    trap = tr;
    #1;
    check(tag, {12'h0, ctl}, {12'h0, exp});
    @(negedge clock);
  endtask

  task automatic fetch(input logic [31:0] w);
    opcode = w[6:0];
    funct3 = w[14:12];
    funct7 = w[31:25];
    cyc(1'b0, 1'b0, "fetch", RD);
    cyc(1'b1, 1'b0, "fetch_ack", RD | IRE);
  endtask

  task automatic alu_op(input logic [31:0] w, input string tag,
                        input logic [19:0] exp);
    fetch(w);
    cyc(1'b0, 1'b0, "decode", 20'h0);
    cyc(1'b0, 1'b0, tag, exp);
  endtask

  initial begin
    reset = 1'b1;
    {opcode, funct3, funct7} = '0;
    {zero, negative, carry_out, overflow, trap} = '0;
    mif.mem_ack = 1'b0;
    @(negedge clock);
    cyc(1'b1, 1'b0, "reset", 20'h0);
    cyc(1'b0, 1'b0, "reset2", 20'h0);
    reset = 1'b0;

    alu_op(32'h002081B3, "add", PCE | WRE);
    alu_op(32'h402081B3, "sub", PCE | WRE | SUB);
    alu_op(32'h4030D193, "srai", PCE | WRE | ALUB | ARI | F101);
    alu_op(32'h0050A193, "slti", PCE | WRE | ALUB | SUB | F010);
    alu_op(32'h123451B7, "lui", PCE | WRE | ALUB);
    alu_op(32'h00001197, "auipc", PCE | WRE | ALUA | ALUB);
    alu_op(32'h008000EF, "jal", PCE | WRE | PSRC | S11);
    alu_op(32'h000080E7, "jalr", PCE | WRE | PSRC | APC | S11);

    negative = 1'b1;
    alu_op(32'h0020C463, "blt_t", PCE | SUB | PSRC);
    overflow = 1'b1;
    alu_op(32'h0020C463, "blt_nt", PCE | SUB);
    {negative, overflow} = 2'b00;
    carry_out = 1'b1;
    alu_op(32'h0020F463, "bgeu_t", PCE | SUB | PSRC);
    carry_out = 1'b0;
    zero = 1'b1;
    alu_op(32'h00208463, "beq_t", PCE | SUB | PSRC);
    zero = 1'b0;

    fetch(32'h0000A183);
    cyc(1'b0, 1'b0, "lw_dec", 20'h0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b0, "lw_wait", MAS | ALUB | RD);
    cyc(1'b1, 1'b0, "lw_ack", MAS | ALUB | RD | PCE | WRE | S10);

    fetch(32'h0030A023);
    cyc(1'b0, 1'b0, "sw_dec", 20'h0);
    cyc(1'b0, 1'b0, "sw_wait", MAS | ALUB | WR);
    cyc(1'b0, 1'b0, "sw_wait", MAS | ALUB | WR);
    cyc(1'b1, 1'b0, "sw_ack", MAS | ALUB | WR | PCE);

    fetch(32'h0000007F);
    cyc(1'b0, 1'b0, "ill_7f", ILL);
    fetch(32'h022081B3);
    cyc(1'b0, 1'b0, "ill_f7", ILL);
    fetch(32'h0020A463);
    cyc(1'b0, 1'b0, "ill_br", ILL);
    fetch(32'h00000073);
    cyc(1'b0, 1'b0, "ecall", ECL);
    fetch(32'h0000000F);
    cyc(1'b0, 1'b0, "fence", PCE);

    fetch(32'h0000A183);
    cyc(1'b0, 1'b0, "lw_dec", 20'h0);
    cyc(1'b0, 1'b0, "lw_wait", MAS | ALUB | RD);
    cyc(1'b1, 1'b1, "trap_ack", MAS | ALUB);

    fetch(32'h00000000);
    cyc(1'b0, 1'b0, "halt_dec", 20'h0);
    cyc(1'b1, 1'b0, "halt", 20'h0);
    cyc(1'b0, 1'b0, "halt", 20'h0);
    cyc(1'b0, 1'b1, "halt_trap", 20'h0);

    cyc(1'b0, 1'b0, "fetch_mid", RD);
    reset = 1'b1;
    cyc(1'b1, 1'b0, "rst_mid", 20'h0);
    cyc(1'b0, 1'b0, "rst_mid2", 20'h0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, "rst_fetch", RD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
